// File: rtl/seven_seg_scan_driver_if.sv
// Load handshake between the value source and seven_seg_scan_driver.
// The source drives num_valid/num; the driver reports num_ready/busy.
interface seven_seg_scan_driver_if #(
    parameter int unsigned BIN_WIDTH = 13
);
    logic                 num_valid;
    logic [BIN_WIDTH-1:0] num;
    logic                 num_ready;
    logic                 busy;

    modport master (output num_valid, num, input num_ready, busy);
    modport slave  (input num_valid, num, output num_ready, busy);
endinterface

// File: rtl/seven_seg_scan_driver.sv
// N-digit multiplexed common-anode 7-seg driver with a serial binary-to-BCD converter.
// Optional macro LEADING_ZERO_BLANK_EN blanks zeros left of the most-significant non-zero digit.
module seven_seg_scan_driver #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned BIN_WIDTH  = 13,
    parameter int unsigned PRESCALE_W = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    seven_seg_scan_driver_if.slave bus,
    output logic                  overflow,
    output logic [NUM_DIGITS-1:0] Anode,
    output logic [6:0]            LED_out
);
    localparam int unsigned DigW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CntW = $clog2(BIN_WIDTH + 1);
    localparam int unsigned ScrW = 4 * NUM_DIGITS;

    typedef enum logic [1:0] {StIdle, StConv, StCommit} state_e;

    state_e               state_q, state_d;
    logic [BIN_WIDTH-1:0] shreg_q, shreg_d;
    logic [ScrW-1:0]      scr_q, scr_d, scr_adj;
    logic [ScrW-1:0]      disp_q, disp_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 ovf_s_q, ovf_s_d;
    logic                 ovf_q, ovf_d;
    logic                 ready;
    logic                 load;

    logic [PRESCALE_W-1:0] presc_q;
    logic [DigW-1:0]       idx_q, idx_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [6:0]            led_q, led_d;
    logic [3:0]            digit;
`ifdef LEADING_ZERO_BLANK_EN
    logic                  all_zero;
    logic                  blank;
`endif

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b0000001;
            4'd1:    seg_of = 7'b1001111;
            4'd2:    seg_of = 7'b0010010;
            4'd3:    seg_of = 7'b0000110;
            4'd4:    seg_of = 7'b1001100;
            4'd5:    seg_of = 7'b0100100;
            4'd6:    seg_of = 7'b0100000;
            4'd7:    seg_of = 7'b0001111;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0000100;
            default: seg_of = 7'b1111111;
        endcase
    endfunction

    assign ready         = (state_q == StIdle);
    assign bus.num_ready = ready;
    assign bus.busy      = ~ready;
    assign load          = bus.num_valid && ready;
    assign overflow      = ovf_q;
    assign Anode         = anode_q;
    assign LED_out       = led_q;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        ovf_s_d = ovf_s_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        scr_adj = scr_q;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
        end
        unique case (state_q)
            StIdle: begin
                if (load) begin
                    shreg_d = bus.num;
                    scr_d   = '0;
                    cnt_d   = CntW'(BIN_WIDTH);
                    ovf_s_d = 1'b0;
                    state_d = StConv;
                end
            end
            StConv: begin
                // A carry out of the top digit means the value no longer fits in NUM_DIGITS.
                {scr_d, shreg_d} = {scr_adj[ScrW-2:0], shreg_q, 1'b0};
                if (scr_adj[ScrW-1]) ovf_s_d = 1'b1;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) state_d = StCommit;
            end
            StCommit: begin
                disp_d  = scr_q;
                ovf_d   = ovf_s_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        idx_d = idx_q;
        if (&presc_q) begin
            idx_d = (idx_q == DigW'(NUM_DIGITS - 1)) ? '0 : idx_q + DigW'(1);
        end
    end

    // Index 0 is the leftmost (most-significant) digit.
    always_comb begin
        digit   = 4'd0;
        anode_d = '1;
`ifdef LEADING_ZERO_BLANK_EN
        all_zero = 1'b1;
        blank    = 1'b0;
`endif
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
`ifdef LEADING_ZERO_BLANK_EN
            all_zero = all_zero & (disp_q[4*(NUM_DIGITS-1-i) +: 4] == 4'd0);
`endif
            if (idx_q == DigW'(i)) begin
                digit                    = disp_q[4*(NUM_DIGITS-1-i) +: 4];
                anode_d[NUM_DIGITS-1-i] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
                blank = all_zero && (i != int'(NUM_DIGITS) - 1);
`endif
            end
        end
        if (ovf_q) begin
            led_d = 7'b1111110;
        end else begin
            led_d = seg_of(digit);
`ifdef LEADING_ZERO_BLANK_EN
            if (blank) led_d = 7'b1111111;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            shreg_q <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            ovf_s_q <= 1'b0;
            ovf_q   <= 1'b0;
            disp_q  <= '0;
            presc_q <= '0;
            idx_q   <= '0;
            anode_q <= '1;
            led_q   <= 7'b1111111;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            ovf_s_q <= ovf_s_d;
            ovf_q   <= ovf_d;
            disp_q  <= disp_d;
            presc_q <= presc_q + PRESCALE_W'(1);
            idx_q   <= idx_d;
            anode_q <= anode_d;
            led_q   <= led_d;
        end
    end
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver with 4-, 3- and 5-digit instances (PRESCALE_W=2).
module tb_seven_seg_scan_driver;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110, S4 = 7'b1001100, S7 = 7'b0001111;
    localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0000100, SD = 7'b1111110;
    localparam logic [6:0] SB = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = SB;
`else
    localparam logic [6:0] LZ = S0;
`endif

    seven_seg_scan_driver_if #(.BIN_WIDTH(13)) if4 (), if3 (), if5 ();
    logic       ovf4, ovf3, ovf5;
    logic [3:0] an4;
    logic [2:0] an3;
    logic [4:0] an5;
    logic [6:0] led4, led3, led5;

    seven_seg_scan_driver #(.NUM_DIGITS(4), .BIN_WIDTH(13), .PRESCALE_W(2)) u_d4 (
        .clk(clk), .rst(rst), .bus(if4), .overflow(ovf4), .Anode(an4), .LED_out(led4));
    seven_seg_scan_driver #(.NUM_DIGITS(3), .BIN_WIDTH(13), .PRESCALE_W(2)) u_d3 (
        .clk(clk), .rst(rst), .bus(if3), .overflow(ovf3), .Anode(an3), .LED_out(led3));
    seven_seg_scan_driver #(.NUM_DIGITS(5), .BIN_WIDTH(13), .PRESCALE_W(2)) u_d5 (
        .clk(clk), .rst(rst), .bus(if5), .overflow(ovf5), .Anode(an5), .LED_out(led5));

    function automatic logic [7:0] get_an(int s);
        case (s)
            3:       return {5'b0, an3};
            4:       return {4'b0, an4};
            default: return {3'b0, an5};
        endcase
    endfunction

    function automatic logic [6:0] get_led(int s);
        case (s)
            3:       return led3;
            4:       return led4;
            default: return led5;
        endcase
    endfunction

    function automatic logic get_rdy(int s);
        case (s)
            3:       return if3.num_ready;
            4:       return if4.num_ready;
            default: return if5.num_ready;
        endcase
    endfunction

    task automatic set_in(int s, logic v, logic [12:0] n);
        case (s)
            3:       begin if3.num_valid = v; if3.num = n; end
            4:       begin if4.num_valid = v; if4.num = n; end
            default: begin if5.num_valid = v; if5.num = n; end
        endcase
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Load a value, count cycles with num_ready low, expect BIN_WIDTH+1 = 14.
    task automatic load_wait(string tag, int s, logic [12:0] val);
        int lat;
        @(negedge clk);
        set_in(s, 1'b1, val);
        @(posedge clk);
        #1 set_in(s, 1'b0, 13'd0);
        lat = 0;
        @(negedge clk);
        while (!get_rdy(s) && lat < 60) begin
            lat++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, lat, 14);
    endtask

    // leds[n-1] is the leftmost digit; checks 4-cycle hold per digit and the wrap back to 0.
    task automatic scan_verify(string tag, int s, int n, logic [7:0][6:0] leds);
        int guard, mask, last, pos, exp_an;
        mask  = (1 << n) - 1;
        last  = mask & ~1;
        guard = 0;
        @(negedge clk);
        while (int'(get_an(s)) != last && guard < 100) begin guard++; @(negedge clk); end
        while (int'(get_an(s)) == last && guard < 100) begin guard++; @(negedge clk); end
        chk({tag, "_sync"}, guard < 100, 1);
        for (int k = 0; k <= 4 * n; k++) begin
            pos    = (k / 4) % n;
            exp_an = mask & ~(1 << (n - 1 - pos));
            chk({tag, "_anode"}, get_an(s), exp_an);
            chk({tag, "_led"}, get_led(s), leds[n-1-pos]);
            if (k != 4 * n) @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst = 1'b1;
        set_in(3, 1'b0, 13'd0);
        set_in(4, 1'b0, 13'd0);
        set_in(5, 1'b0, 13'd0);
        #1;
        chk("por_anode", an4, 4'b1111);
        chk("por_led", led4, SB);
        chk("por_ready", if4.num_ready, 1'b1);
        chk("por_busy", if4.busy, 1'b0);
        chk("por_ovf", ovf4, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Overflow on 3 digits
        load_wait("ovf1000", 3, 13'd1000);
        chk("ovf1000_flag", ovf3, 1'b1);
        scan_verify("ovf1000", 3, 3, {SD, SD, SD});

        // Asynchronous reset mid-scan, observed before any clock edge
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_anode", an4, 4'b1111);
        chk("rst_led", led4, SB);
        chk("rst_ovf", ovf3, 1'b0);
        chk("rst_ready", if3.num_ready, 1'b1);
        chk("rst_anode3", an3, 3'b111);
        @(negedge clk);
        rst = 1'b0;

        load_wait("ovf999", 3, 13'd999);
        chk("ovf999_flag", ovf3, 1'b0);
        scan_verify("ovf999", 3, 3, {S9, S9, S9});

        // Main function: 1234
        load_wait("l1234", 4, 13'd1234);
        chk("l1234_ovf", ovf4, 1'b0);
        scan_verify("l1234", 4, 4, {S1, S2, S3, S4});

        // num_valid while busy is dropped
        @(negedge clk);
        set_in(4, 1'b1, 13'd42);
        @(posedge clk);
        #1 set_in(4, 1'b0, 13'd0);
        lat = 0;
        @(negedge clk);
        while (!get_rdy(4) && lat < 60) begin
            lat++;
            if (lat == 5) set_in(4, 1'b1, 13'd555);
            else set_in(4, 1'b0, 13'd0);
            @(negedge clk);
        end
        set_in(4, 1'b0, 13'd0);
        chk("busy_latency", lat, 14);
        repeat (3) @(negedge clk);
        chk("busy_noqueue", if4.num_ready, 1'b1);
        scan_verify("busy42", 4, 4, {LZ, LZ, S4, S2});

        // Reset mid-conversion loses the value
        @(negedge clk);
        set_in(4, 1'b1, 13'd8191);
        @(posedge clk);
        #1 set_in(4, 1'b0, 13'd0);
        repeat (7) @(posedge clk);
        chk("midconv_busy", if4.busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("midconv_ready", if4.num_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        scan_verify("midconv_zero", 4, 4, {LZ, LZ, LZ, S0});
        load_wait("reload8191", 4, 13'd8191);
        scan_verify("reload8191", 4, 4, {S8, S1, S9, S1});

        // Leading zeros and 5-digit wrap
        load_wait("l7", 4, 13'd7);
        scan_verify("l7", 4, 4, {LZ, LZ, LZ, S7});
        load_wait("d5_8191", 5, 13'd8191);
        chk("d5_ovf", ovf5, 1'b0);
        scan_verify("d5_8191", 5, 5, {LZ, S8, S1, S9, S1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
